wb_arbiter_regfile: RTL and testbench

//  Parametrised writeback stage plus integer register file for the in-order core.
//  NUM_CH producer channels (ALU, MEM, link/PC+4, ...) compete for the single GPR

---
 rtl/wb_arbiter_regfile.sv | 197 +++++++++++++++++++
 tb/tb_wb_arbiter_regfile.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter_regfile
//  Purpose  : Writeback stage and integer register file for the in-order
//             core. NUM_CH producers compete for the single GPR write port
//             through a round-robin valid/ready arbiter. A per-register
//             pending counter flags RAW hazards to decode. Two combinational
//             read ports with write-first bypass feed decode.
//  Ports    : clk_i, rst_ni            clock, async active-low reset
//             ch_valid_i/ch_ready_o    per-channel handshake (ready one-hot)
//             ch_rd_i/ch_data_i        per-channel destination and result
//             ch_link_i                result is a PC, commit PC+4
//             rsv_en_i/rsv_rd_i        decoder reservation of a destination
//             rsv_full_o               pending counter of rsv_rd_i saturated
//             rs{1,2}_addr_i           read addresses
//             rs{1,2}_data_o           read data (bypassed)
//             rs{1,2}_busy_o           register has pending writes
//             wb_valid_o/wb_rd_o/wb_data_o  registered commit record
//             en_trace_i               trace enable (simulation-only facility)
//  Revision : 1.0  initial release
// ============================================================================
module wb_arbiter_regfile #(
    parameter int XLEN   = 32,
    parameter int NUM_CH = 3,
    parameter int NREG   = 32,
    parameter int PEND_W = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_CH-1:0]               ch_valid_i,
    output logic [NUM_CH-1:0]               ch_ready_o,
    input  logic [NUM_CH*$clog2(NREG)-1:0]  ch_rd_i,
    input  logic [NUM_CH*XLEN-1:0]          ch_data_i,
    input  logic [NUM_CH-1:0]               ch_link_i,
    input  logic                            rsv_en_i,
    input  logic [$clog2(NREG)-1:0]         rsv_rd_i,
    output logic                            rsv_full_o,
    input  logic [$clog2(NREG)-1:0]         rs1_addr_i,
    input  logic [$clog2(NREG)-1:0]         rs2_addr_i,
    output logic [XLEN-1:0]                 rs1_data_o,
    output logic [XLEN-1:0]                 rs2_data_o,
    output logic                            rs1_busy_o,
    output logic                            rs2_busy_o,
    output logic                            wb_valid_o,
    output logic [$clog2(NREG)-1:0]         wb_rd_o,
    output logic [XLEN-1:0]                 wb_data_o,
    input  logic                            en_trace_i
);

    localparam int AW = $clog2(NREG);
    // Pointer width kept at least 1 so a single-channel build still elaborates.
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    // Trace logging is a simulation-side facility; the synthesizable block
    // only carries the enable through the interface.
    wire unused_trace = &{1'b0, en_trace_i};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [XLEN-1:0]   gpr_q [NREG];
    logic [PEND_W-1:0] cnt_q [NREG];
    logic [PEND_W-1:0] cnt_d [NREG];
    logic              wb_valid_q;
    logic [AW-1:0]     wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    // Channel index rr_ptr+offset, wrapped at NUM_CH (offset < NUM_CH).
    function automatic logic [PW-1:0] f_wrap(input int v);
        int w;
        w = v;
        if (w >= NUM_CH) w = w - NUM_CH;
        return PW'(w);
    endfunction

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic          grant_vld;
    logic [PW-1:0] grant_idx;

    // Scan offsets from highest to lowest so the closest valid channel at
    // or after rr_ptr is the last one written, i.e. the winner.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_valid_i[f_wrap(int'(rr_ptr_q) + k)]) begin
                grant_vld = 1'b1;
                grant_idx = f_wrap(int'(rr_ptr_q) + k);
            end
        end
    end

    always_comb begin
        ch_ready_o = '0;
        if (grant_vld) ch_ready_o[grant_idx] = 1'b1;
    end

    // Ready is only ever raised towards a valid channel, so a grant is an accept.
    logic            accept;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            sel_link;
    logic [XLEN-1:0] wr_value;
    logic            wr_en;

    assign accept   = grant_vld;
    assign sel_rd   = ch_rd_i[int'(grant_idx) * AW +: AW];
    assign sel_data = ch_data_i[int'(grant_idx) * XLEN +: XLEN];
    assign sel_link = ch_link_i[grant_idx];
    // Link results commit PC+4; the carry out of the adder is discarded.
    assign wr_value = sel_link ? (sel_data + XLEN'(4)) : sel_data;
    assign wr_en    = accept && (sel_rd != '0);

    assign rr_ptr_d = accept ? f_wrap(int'(grant_idx) + 1) : rr_ptr_q;

    // ------------------------------------------------------------------
    // Read ports with write-first bypass
    // ------------------------------------------------------------------
    always_comb begin
        rs1_data_o = gpr_q[rs1_addr_i];
        if (rs1_addr_i == '0)                     rs1_data_o = '0;
        else if (accept && (sel_rd == rs1_addr_i)) rs1_data_o = wr_value;
    end

    always_comb begin
        rs2_data_o = gpr_q[rs2_addr_i];
        if (rs2_addr_i == '0)                     rs2_data_o = '0;
        else if (accept && (sel_rd == rs2_addr_i)) rs2_data_o = wr_value;
    end

    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
    assign rsv_full_o = (rsv_rd_i != '0) && (cnt_q[rsv_rd_i] == CNT_MAX);
    assign rs1_busy_o = (rs1_addr_i != '0) && (cnt_q[rs1_addr_i] != '0);
    assign rs2_busy_o = (rs2_addr_i != '0) && (cnt_q[rs2_addr_i] != '0);

    logic rsv_ok;
    assign rsv_ok = rsv_en_i && !rsv_full_o;

    // A reserve and a writeback on the same register cancel out. A
    // writeback with nothing pending leaves the counter at zero.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r != 0) begin
                if (rsv_ok && (rsv_rd_i == AW'(r))) begin
                    if (!(accept && (sel_rd == AW'(r))))
                        cnt_d[r] = cnt_q[r] + 1'b1;
                end else if (accept && (sel_rd == AW'(r)) && (cnt_q[r] != '0)) begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit record
    // ------------------------------------------------------------------
    assign wb_rd_d   = accept ? sel_rd   : wb_rd_q;
    assign wb_data_d = accept ? wr_value : wb_data_q;

    assign wb_valid_o = wb_valid_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            for (int r = 0; r < NREG; r++) begin
                gpr_q[r] <= '0;
                cnt_q[r] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wb_valid_q <= accept;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            if (wr_en) gpr_q[sel_rd] <= wr_value;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter_regfile
//  Purpose  : Self-checking bench for wb_arbiter_regfile: table of arbiter /
//             read-port vectors, hand sequences for the pending counters and
//             asynchronous reset, and a commit scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_arbiter_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ch_valid;
    logic [2:0]  ch_ready;
    logic [14:0] ch_rd;
    logic [95:0] ch_data;
    logic [2:0]  ch_link;
    logic        rsv_en;
    logic [4:0]  rsv_rd;
    logic        rsv_full;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_arbiter_regfile #(.XLEN(32), .NUM_CH(3), .NREG(32), .PEND_W(2)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ch_valid_i (ch_valid),
        .ch_ready_o (ch_ready),
        .ch_rd_i    (ch_rd),
        .ch_data_i  (ch_data),
        .ch_link_i  (ch_link),
        .rsv_en_i   (rsv_en),
        .rsv_rd_i   (rsv_rd),
        .rsv_full_o (rsv_full),
        .rs1_addr_i (rs1_addr),
        .rs2_addr_i (rs2_addr),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .wb_valid_o (wb_valid),
        .wb_rd_o    (wb_rd),
        .wb_data_o  (wb_data),
        .en_trace_i (1'b0)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;
    wb_t sb[$];

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  link;
        logic [14:0] rd;
        logic [95:0] data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  e_ready;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic        push;
        logic [4:0]  w_rd;
        logic [31:0] w_data;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(input logic [2:0] valid, input logic [2:0] link,
                                input logic [4:0] rd2, input logic [4:0] rd1, input logic [4:0] rd0,
                                input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
                                input logic [4:0] a1, input logic [4:0] a2, input logic [2:0] er,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic p, input logic [4:0] wr, input logic [31:0] wd);
        vec_t v;
        v.valid = valid; v.link = link; v.rd = {rd2, rd1, rd0}; v.data = {d2, d1, d0};
        v.rs1 = a1; v.rs2 = a2; v.e_ready = er; v.e_rs1 = e1; v.e_rs2 = e2;
        v.push = p; v.w_rd = wr; v.w_data = wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus 1 time unit after the edge, return just
    // before the falling edge so combinational outputs can be sampled.
    task automatic drive(input logic [2:0] valid, input logic [2:0] link, input logic [14:0] rd,
                         input logic [95:0] data, input logic ren, input logic [4:0] rrd,
                         input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #1;
        ch_valid = valid; ch_link = link; ch_rd = rd; ch_data = data;
        rsv_en = ren; rsv_rd = rrd; rs1_addr = a1; rs2_addr = a2;
        #3;
    endtask

    // One cycle on x7 using channel 0 only; reads and reservation target x7.
    task automatic s7(input logic v0, input logic [31:0] d0, input logic ren);
        wb_t e;
        drive({2'b00, v0}, 3'b000, {10'd0, 5'd7}, {64'd0, d0}, ren, 5'd7, 5'd7, 5'd7);
        if (v0) begin
            e.rd = 5'd7; e.data = d0;
            sb.push_back(e);
        end
    endtask

    // Commit monitor: every strobe must match the oldest expected record.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h expected no commit", wb_rd, wb_data);
            end else begin
                wb_t e;
                e = sb.pop_front();
                if (wb_rd !== e.rd || wb_data !== e.data) begin
                    n_fail++;
                    $display("FAIL wb_commit: got rd=%0d data=%h expected rd=%0d data=%h",
                             wb_rd, wb_data, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ch_valid = '0; ch_link = '0; ch_rd = '0; ch_data = '0;
        rsv_en = 1'b0; rsv_rd = '0; rs1_addr = 5'd5; rs2_addr = '0;

        //                valid   link   rd2 rd1 rd0  d2            d1        d0          a1 a2 ready   e_rs1         e_rs2     push wrd wdata
        vt.push_back(mk(3'b000, 3'b000, 0, 0, 0,  0,            0,        0,          5, 0, 3'b000, 0,            0,        0, 0, 0));
        vt.push_back(mk(3'b001, 3'b000, 0, 0, 5,  0,            0,        32'h1234,   5, 5, 3'b001, 32'h1234,     32'h1234, 1, 5, 32'h1234));
        vt.push_back(mk(3'b000, 3'b000, 0, 0, 0,  0,            0,        0,          5, 1, 3'b000, 32'h1234,     0,        0, 0, 0));
        vt.push_back(mk(3'b100, 3'b100, 1, 0, 0,  32'hFFFFFFFC, 0,        0,          1, 5, 3'b100, 0,            32'h1234, 1, 1, 0));
        vt.push_back(mk(3'b111, 3'b000, 5, 4, 3,  32'hA5,       32'hA4,   32'hA3,     3, 4, 3'b001, 32'hA3,       0,        1, 3, 32'hA3));
        vt.push_back(mk(3'b111, 3'b000, 5, 4, 3,  32'hA5,       32'hA4,   32'hA3,     3, 4, 3'b010, 32'hA3,       32'hA4,   1, 4, 32'hA4));
        vt.push_back(mk(3'b111, 3'b000, 5, 4, 3,  32'hA5,       32'hA4,   32'hA3,     5, 4, 3'b100, 32'hA5,       32'hA4,   1, 5, 32'hA5));
        vt.push_back(mk(3'b111, 3'b000, 5, 4, 3,  32'hA5,       32'hA4,   32'hB3,     5, 3, 3'b001, 32'hA5,       32'hB3,   1, 3, 32'hB3));
        vt.push_back(mk(3'b101, 3'b100, 6, 0, 7,  32'h100,      0,        32'h77,     6, 3, 3'b100, 32'h104,      32'hB3,   1, 6, 32'h104));
        vt.push_back(mk(3'b010, 3'b000, 0, 0, 0,  0,            32'hDEAD, 0,          0, 6, 3'b010, 0,            32'h104,  1, 0, 32'hDEAD));
        vt.push_back(mk(3'b011, 3'b000, 0, 9, 8,  0,            32'h99,   32'h88,     8, 9, 3'b001, 32'h88,       0,        1, 8, 32'h88));
        vt.push_back(mk(3'b000, 3'b000, 0, 0, 0,  0,            0,        0,          0, 8, 3'b000, 0,            32'h88,   0, 0, 0));

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #3;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
        chk("rst_ready",    {29'd0, ch_ready}, 32'd0);

        foreach (vt[i]) begin
            drive(vt[i].valid, vt[i].link, vt[i].rd, vt[i].data, 1'b0, 5'd0, vt[i].rs1, vt[i].rs2);
            chk($sformatf("v%0d_ready", i), {29'd0, ch_ready}, {29'd0, vt[i].e_ready});
            chk($sformatf("v%0d_rs1", i), rs1_data, vt[i].e_rs1);
            chk($sformatf("v%0d_rs2", i), rs2_data, vt[i].e_rs2);
            chk($sformatf("v%0d_busy", i), {30'd0, rs1_busy, rs2_busy}, 32'd0);
            if (vt[i].push) begin
                wb_t e;
                e.rd = vt[i].w_rd; e.data = vt[i].w_data;
                sb.push_back(e);
            end
        end

        // x0 is never reserved
        drive(3'b000, 3'b000, '0, '0, 1'b1, 5'd0, 5'd0, 5'd0);
        chk("x0_full", {31'd0, rsv_full}, 32'd0);
        drive(3'b000, 3'b000, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("x0_busy", {30'd0, rs1_busy, rs2_busy}, 32'd0);

        // Pending counter on x7: saturate, drain, cancel, no underflow
        s7(1'b0, 32'h0, 1'b1);  chk("p1_full", {31'd0, rsv_full}, 32'd0);
                                chk("p1_busy", {31'd0, rs1_busy}, 32'd0);
        s7(1'b0, 32'h0, 1'b1);  chk("p2_busy", {31'd0, rs1_busy}, 32'd1);
                                chk("p2_full", {31'd0, rsv_full}, 32'd0);
        s7(1'b0, 32'h0, 1'b1);  chk("p3_full", {31'd0, rsv_full}, 32'd0);
        s7(1'b0, 32'h0, 1'b1);  chk("p4_full", {31'd0, rsv_full}, 32'd1);
        s7(1'b0, 32'h0, 1'b0);  chk("p5_full", {31'd0, rsv_full}, 32'd1);
                                chk("p5_busy2", {31'd0, rs2_busy}, 32'd1);
        s7(1'b1, 32'h71, 1'b0); chk("p6_ready", {29'd0, ch_ready}, 32'd1);
                                chk("p6_rs1", rs1_data, 32'h71);
        s7(1'b1, 32'h72, 1'b0); chk("p7_full", {31'd0, rsv_full}, 32'd0);
                                chk("p7_busy", {31'd0, rs1_busy}, 32'd1);
        s7(1'b1, 32'h73, 1'b0); chk("p8_busy", {31'd0, rs1_busy}, 32'd1);
        s7(1'b0, 32'h0, 1'b0);  chk("p9_busy", {31'd0, rs1_busy}, 32'd0);
                                chk("p9_rs1", rs1_data, 32'h73);
        s7(1'b0, 32'h0, 1'b1);  chk("p10_busy", {31'd0, rs1_busy}, 32'd0);
        s7(1'b1, 32'h74, 1'b1); chk("p11_busy", {31'd0, rs1_busy}, 32'd1);
        s7(1'b0, 32'h0, 1'b0);  chk("p12_busy", {31'd0, rs1_busy}, 32'd1);
        s7(1'b1, 32'h75, 1'b0); chk("p13_busy", {31'd0, rs1_busy}, 32'd1);
        s7(1'b0, 32'h0, 1'b0);  chk("p14_busy", {31'd0, rs1_busy}, 32'd0);
        s7(1'b1, 32'h76, 1'b0); chk("p15_busy", {31'd0, rs1_busy}, 32'd0);
        s7(1'b0, 32'h0, 1'b0);  chk("p16_busy", {31'd0, rs1_busy}, 32'd0);
        s7(1'b0, 32'h0, 1'b1);  chk("p17_busy", {31'd0, rs1_busy}, 32'd0);
        s7(1'b0, 32'h0, 1'b0);  chk("p18_busy", {31'd0, rs1_busy}, 32'd1);
                                chk("p18_busy2", {31'd0, rs2_busy}, 32'd1);
        s7(1'b1, 32'h77, 1'b0); chk("p19_busy", {31'd0, rs1_busy}, 32'd1);
        s7(1'b0, 32'h0, 1'b0);  chk("p20_busy", {31'd0, rs1_busy}, 32'd0);

        // Asynchronous reset mid-stream: x10 written, x9 reserved, rr_ptr moved
        drive(3'b001, 3'b000, {10'd0, 5'd10}, {64'd0, 32'h55}, 1'b1, 5'd9, 5'd10, 5'd9);
        chk("r1_ready", {29'd0, ch_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("r2_pre_wb_valid", {31'd0, wb_valid}, 32'd1);
        rst_n = 1'b0;
        ch_valid = 3'b001; ch_rd = {10'd0, 5'd11}; ch_data = {64'd0, 32'h66};
        rsv_en = 1'b0; rs1_addr = 5'd10; rs2_addr = 5'd9;
        #3;
        chk("r2_rs1_x10", rs1_data, 32'd0);
        chk("r2_busy_x9", {31'd0, rs2_busy}, 32'd0);
        chk("r2_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("r2_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("r2_wb_data", wb_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ch_valid = 3'b000; rs1_addr = 5'd11; rs2_addr = 5'd5;
        #3;
        chk("r3_rs1_x11", rs1_data, 32'd0);
        chk("r3_rs2_x5", rs2_data, 32'd0);
        chk("r3_wb_valid", {31'd0, wb_valid}, 32'd0);
        drive(3'b111, 3'b000, {5'd14, 5'd13, 5'd12}, {32'hE, 32'hD, 32'hC}, 1'b0, 5'd0, 5'd12, 5'd13);
        chk("r4_ready", {29'd0, ch_ready}, 32'd1);
        chk("r4_rs1", rs1_data, 32'hC);
        chk("r4_rs2", rs2_data, 32'd0);
        begin
            wb_t e;
            e.rd = 5'd12; e.data = 32'hC;
            sb.push_back(e);
        end
        drive(3'b000, 3'b000, '0, '0, 1'b0, 5'd0, 5'd12, 5'd0);
        chk("r5_rs1", rs1_data, 32'hC);

        repeat (3) @(posedge clk);
        #4;
        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
